hazard_unit_mc: RTL and testbench

- Next-generation hazard/forwarding controller for the 5-stage pipelined MIPS core (F/D/E/M/W).
- Register-address width is parametrised, and branch resolution stage is selectable (D or E).
- Adds a sequential busy tracker for the multi-cycle mult/div unit that stalls dependent HI/LO readers.
- Adds a saturating stall-cycle performance counter.

---
 rtl/hazard_unit_mc.sv | 123 ++++++++++++
 tb/tb_hazard_unit_mc.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit_mc.sv
`default_nettype none
// ============================================================================
// hazard_unit_mc : stall/flush/forward control for the 5-stage MIPS pipeline,
//                  with a mult/div busy tracker and a saturating stall counter.
// Revision       : 1.0
// ============================================================================
module hazard_unit_mc #(
  parameter int REG_AW      = 5,
  parameter int MULDIV_LAT  = 4,
  parameter int CNT_W       = 16,
  parameter int BRANCH_IN_D = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              BranchD,
  input  logic [REG_AW-1:0] RsD,
  input  logic [REG_AW-1:0] RtD,
  input  logic [REG_AW-1:0] RsE,
  input  logic [REG_AW-1:0] RtE,
  input  logic [REG_AW-1:0] WriteRegE,
  input  logic              MemtoRegE,
  input  logic              RegWriteE,
  input  logic [REG_AW-1:0] WriteRegM,
  input  logic              MemtoRegM,
  input  logic              RegWriteM,
  input  logic [REG_AW-1:0] WriteRegW,
  input  logic              RegWriteW,
  input  logic              MulDivStartE,
  input  logic              UsesHiLoD,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushE,
  output logic              ForwardAD,
  output logic              ForwardBD,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              MulDivBusy,
  output logic [CNT_W-1:0]  StallCount
);

  localparam int                  c_busy_w   = $clog2(MULDIV_LAT + 1);
  localparam logic [c_busy_w-1:0] c_lat      = c_busy_w'(MULDIV_LAT);
  localparam logic [c_busy_w-1:0] c_busy_one = c_busy_w'(1);
  localparam logic [CNT_W-1:0]    c_cnt_one  = CNT_W'(1);

  logic [c_busy_w-1:0] busy_cnt_q, busy_cnt_d;
  logic [CNT_W-1:0]    stall_cnt_q, stall_cnt_d;

  logic       w_lwstall, w_branchstall, w_hilostall, w_stall, w_busy;
  logic       w_fwd_ad, w_fwd_bd;
  logic [1:0] w_fwd_ae, w_fwd_be;

  // M stage has priority over W: it holds the younger value.
  always_comb begin
    w_fwd_ae = 2'b00;
    if (RegWriteM && WriteRegM != '0 && RsE == WriteRegM)
      w_fwd_ae = 2'b10;
    else if (RegWriteW && WriteRegW != '0 && RsE == WriteRegW)
      w_fwd_ae = 2'b01;

    w_fwd_be = 2'b00;
    if (RegWriteM && WriteRegM != '0 && RtE == WriteRegM)
      w_fwd_be = 2'b10;
    else if (RegWriteW && WriteRegW != '0 && RtE == WriteRegW)
      w_fwd_be = 2'b01;
  end

  assign w_lwstall = MemtoRegE && WriteRegE != '0 &&
                     (WriteRegE == RsD || WriteRegE == RtD);

  generate
    if (BRANCH_IN_D != 0) begin : g_branch_d
      assign w_fwd_ad = RegWriteM && RsD != '0 && RsD == WriteRegM;
      assign w_fwd_bd = RegWriteM && RtD != '0 && RtD == WriteRegM;
      assign w_branchstall = BranchD &&
        ((RegWriteE && WriteRegE != '0 && (WriteRegE == RsD || WriteRegE == RtD)) ||
         (MemtoRegM && WriteRegM != '0 && (WriteRegM == RsD || WriteRegM == RtD)));
    end else begin : g_branch_e
      assign w_fwd_ad      = 1'b0;
      assign w_fwd_bd      = 1'b0;
      assign w_branchstall = 1'b0;
    end
  endgenerate

  assign w_busy      = (busy_cnt_q != '0);
  assign w_hilostall = UsesHiLoD && (w_busy || MulDivStartE);
  assign w_stall     = (w_lwstall | w_branchstall | w_hilostall) & ~Reset;

  always_comb begin
    busy_cnt_d = busy_cnt_q;
    if (MulDivStartE)
      busy_cnt_d = c_lat;
    else if (w_busy)
      busy_cnt_d = busy_cnt_q - c_busy_one;

    stall_cnt_d = stall_cnt_q;
    if (w_stall && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + c_cnt_one;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      busy_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      busy_cnt_q  <= busy_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Reset forces every control output low without waiting for an edge.
  assign StallF     = w_stall;
  assign StallD     = w_stall;
  assign FlushE     = w_stall;
  assign ForwardAD  = w_fwd_ad & ~Reset;
  assign ForwardBD  = w_fwd_bd & ~Reset;
  assign ForwardAE  = Reset ? 2'b00 : w_fwd_ae;
  assign ForwardBE  = Reset ? 2'b00 : w_fwd_be;
  assign MulDivBusy = w_busy & ~Reset;
  assign StallCount = stall_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_unit_mc.sv
`default_nettype none
// ============================================================================
// tb_hazard_unit_mc : directed vector table plus multi-cycle sequences.
// Revision          : 1.0
// ============================================================================
module tb_hazard_unit_mc;

  logic       clk = 1'b0;
  logic       rst;
  logic       branch_d, mre, rwe, mrm, rwm, rww, start, hilo;
  logic [4:0] rsd, rtd, rse, rte, wre, wrm, wrw;

  logic       sf0, sd0, fe0, fad0, fbd0, busy0;
  logic [1:0] fae0, fbe0;
  logic [3:0] cnt0;
  logic       sf1, sd1, fe1, fad1, fbd1, busy1;
  logic [1:0] fae1, fbe1;
  logic [15:0] cnt1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // dut0: branch in D, 4-bit counter; dut1: branch in E, 16-bit counter.
  hazard_unit_mc #(.REG_AW(5), .MULDIV_LAT(4), .CNT_W(4), .BRANCH_IN_D(1)) dut0 (
    .Clk(clk), .Reset(rst), .BranchD(branch_d), .RsD(rsd), .RtD(rtd), .RsE(rse), .RtE(rte),
    .WriteRegE(wre), .MemtoRegE(mre), .RegWriteE(rwe), .WriteRegM(wrm), .MemtoRegM(mrm),
    .RegWriteM(rwm), .WriteRegW(wrw), .RegWriteW(rww), .MulDivStartE(start), .UsesHiLoD(hilo),
    .StallF(sf0), .StallD(sd0), .FlushE(fe0), .ForwardAD(fad0), .ForwardBD(fbd0),
    .ForwardAE(fae0), .ForwardBE(fbe0), .MulDivBusy(busy0), .StallCount(cnt0));

  hazard_unit_mc #(.REG_AW(5), .MULDIV_LAT(4), .CNT_W(16), .BRANCH_IN_D(0)) dut1 (
    .Clk(clk), .Reset(rst), .BranchD(branch_d), .RsD(rsd), .RtD(rtd), .RsE(rse), .RtE(rte),
    .WriteRegE(wre), .MemtoRegE(mre), .RegWriteE(rwe), .WriteRegM(wrm), .MemtoRegM(mrm),
    .RegWriteM(rwm), .WriteRegW(wrw), .RegWriteW(rww), .MulDivStartE(start), .UsesHiLoD(hilo),
    .StallF(sf1), .StallD(sd1), .FlushE(fe1), .ForwardAD(fad1), .ForwardBD(fbd1),
    .ForwardAE(fae1), .ForwardBE(fbe1), .MulDivBusy(busy1), .StallCount(cnt1));

  typedef struct {
    logic       branch, mre, rwe, mrm, rwm, rww, hilo;
    logic [4:0] rsd, rtd, rse, rte, wre, wrm, wrw;
    logic       stall;    // expected stall, branch in D
    logic       stall_e;  // expected stall, branch in E
    logic       fad, fbd;
    logic [1:0] fae, fbe;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    branch_d = 0; mre = 0; rwe = 0; mrm = 0; rwm = 0; rww = 0; start = 0; hilo = 0;
    rsd = 0; rtd = 0; rse = 0; rte = 0; wre = 0; wrm = 0; wrw = 0;
  endtask

  task automatic apply(input vec_t v);
    branch_d = v.branch; mre = v.mre; rwe = v.rwe; mrm = v.mrm; rwm = v.rwm; rww = v.rww;
    hilo = v.hilo; start = 0;
    rsd = v.rsd; rtd = v.rtd; rse = v.rse; rte = v.rte; wre = v.wre; wrm = v.wrm; wrw = v.wrw;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t v;
    // load-use via Rs, via Rt, and suppressed for register 0
    v = '{default: '0}; v.mre = 1; v.wre = 8; v.rsd = 8; v.stall = 1; v.stall_e = 1; tbl.push_back(v);
    v = '{default: '0}; v.mre = 1; v.wre = 0; v.rsd = 0; tbl.push_back(v);
    v = '{default: '0}; v.mre = 1; v.wre = 9; v.rtd = 9; v.rsd = 3; v.stall = 1; v.stall_e = 1; tbl.push_back(v);
    // forwarding priority and register-0 suppression
    v = '{default: '0}; v.rwm = 1; v.rww = 1; v.wrm = 5; v.wrw = 5; v.rse = 5; v.fae = 2'b10; tbl.push_back(v);
    v = '{default: '0}; v.rww = 1; v.wrm = 5; v.wrw = 5; v.rse = 5; v.fae = 2'b01; tbl.push_back(v);
    v = '{default: '0}; v.rwm = 1; v.rww = 1; tbl.push_back(v);
    v = '{default: '0}; v.rwm = 1; v.wrm = 7; v.rte = 7; v.rww = 1; v.wrw = 6; v.rse = 6;
    v.fae = 2'b01; v.fbe = 2'b10; tbl.push_back(v);
    // branch hazards: E-stage ALU result, M-stage forward, M-stage load
    v = '{default: '0}; v.branch = 1; v.rwe = 1; v.wre = 3; v.rtd = 3; v.stall = 1; tbl.push_back(v);
    v = '{default: '0}; v.branch = 1; v.rwm = 1; v.wrm = 3; v.rtd = 3; v.fbd = 1; tbl.push_back(v);
    v = '{default: '0}; v.branch = 1; v.mrm = 1; v.rwm = 1; v.wrm = 4; v.rsd = 4;
    v.stall = 1; v.fad = 1; tbl.push_back(v);
    v = '{default: '0}; v.rwe = 1; v.wre = 3; v.rtd = 3; tbl.push_back(v);
    v = '{default: '0}; v.branch = 1; v.rwe = 1; tbl.push_back(v);
    v = '{default: '0}; v.hilo = 1; tbl.push_back(v);

    // reset holds every output low even with a load-use hazard presented
    clear_inputs();
    rst = 1;
    mre = 1; wre = 8; rsd = 8; rwm = 1; wrm = 8; rse = 8;
    #2;
    check("rst_stall", {sf0, sd0, fe0, sd1}, 4'b0000);
    check("rst_fwd", {fad0, fae0}, 3'b000);
    check("rst_busy", busy0, 1'b0);
    check("rst_cnt", cnt0, 4'd0);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      apply(tbl[i]);
      #1;
      check($sformatf("v%0d_stall", i), {sf0, sd0, fe0}, {3{tbl[i].stall}});
      check($sformatf("v%0d_stall_e", i), {sf1, sd1, fe1}, {3{tbl[i].stall_e}});
      check($sformatf("v%0d_fwd_d", i), {fad0, fbd0}, {tbl[i].fad, tbl[i].fbd});
      check($sformatf("v%0d_fwd_d_e", i), {fad1, fbd1}, 2'b00);
      check($sformatf("v%0d_fae", i), fae0, tbl[i].fae);
      check($sformatf("v%0d_fbe", i), fbe0, tbl[i].fbe);
    end

    // load-use stall counts one cycle
    do_reset();
    check("cnt_after_reset", cnt0, 4'd0);
    @(negedge clk);
    mre = 1; wre = 8; rsd = 8;
    @(negedge clk);
    clear_inputs();
    #1;
    check("cnt_one", cnt0, 4'd1);

    // mult/div: start at cycle 0, HI/LO reader waiting from cycle 0
    do_reset();
    @(negedge clk);
    start = 1; hilo = 1;
    #1;
    check("md_c0_stall", sd0, 1'b1);
    check("md_c0_busy", busy0, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      start = 0;
      #1;
      check($sformatf("md_c%0d_stall", c), sd0, (c <= 4) ? 1'b1 : 1'b0);
      check($sformatf("md_c%0d_busy", c), busy0, (c <= 4) ? 1'b1 : 1'b0);
      if (c == 5) check("md_cnt", cnt0, 4'd5);
    end

    // asynchronous reset in the middle of a mult/div
    do_reset();
    @(negedge clk);
    start = 1; hilo = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    #1;
    check("mid_busy_pre", busy0, 1'b1);
    #1;
    rst = 1;
    #1;
    check("mid_busy_async", busy0, 1'b0);
    check("mid_cnt_async", cnt0, 4'd0);
    @(negedge clk);
    rst = 0;
    #1;
    check("mid_stall_after", sd0, 1'b0);
    check("mid_busy_after", busy0, 1'b0);

    // restart while busy reloads the full latency
    do_reset();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    @(negedge clk); start = 1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start = 0;
      #1;
      check($sformatf("restart_c%0d_busy", c), busy0, (c <= 4) ? 1'b1 : 1'b0);
    end

    // saturation: 20 stalled cycles
    do_reset();
    @(negedge clk);
    mre = 1; wre = 8; rsd = 8;
    repeat (20) @(negedge clk);
    #1;
    check("sat_cnt4", cnt0, 4'd15);
    check("sat_cnt16", cnt1, 16'd20);
    clear_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
